// File: rtl/upd_dw_mac_if.sv
// Handshake bundle between the update-stage operand reader and the dW/dU MAC.
// The master drives the operand pairs and the slave (the MAC) returns gradient elements.
interface upd_dw_mac_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 12
);
    logic                    i_valid;
    logic signed [WIDTH-1:0] i_d;
    logic signed [WIDTH-1:0] i_x;
    logic signed [WIDTH-1:0] o_dw;
    logic [ADDR_WIDTH-1:0]   o_addr_w;
    logic                    o_valid;
    logic                    o_done;

    modport master (
        output i_valid, i_d, i_x,
        input  o_dw, o_addr_w, o_valid, o_done
    );

    modport slave (
        input  i_valid, i_d, i_x,
        output o_dw, o_addr_w, o_valid, o_done
    );
endinterface

// File: rtl/upd_dw_mac.sv
// Multiply-accumulate of dgate x X/H over TIMESTEP samples, emitting one saturated
// dW/dU element per group with a linear write address for the parameter-update memory.
module upd_dw_mac #(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 12,
    parameter int TIMESTEP   = 7,
    parameter int NUM_CELL   = 53,
    parameter int NUM_INPUT  = 53,
    parameter int ADDR_WIDTH = 12
) (
    input logic         clk,
    input logic         rst,
    upd_dw_mac_if.slave bus
);
    localparam int PROD_W   = 2 * WIDTH;
    localparam int ACC_W    = 2 * WIDTH + 4;
    localparam int T_W      = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
    localparam int NUM_ELEM = NUM_CELL * NUM_INPUT;

    localparam logic [T_W-1:0]          T_LAST  = T_W'(TIMESTEP - 1);
    localparam logic [ADDR_WIDTH-1:0]   E_LAST  = ADDR_WIDTH'(NUM_ELEM - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [PROD_W-1:0] p1;
    logic                     v1;
    logic                     last1;
    logic [T_W-1:0]           t_cnt;
    logic [ADDR_WIDTH-1:0]    e_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [WIDTH-1:0]  sat;

    // The closing sum includes the final product so the accumulator can restart at zero.
    always_comb begin
        sum     = acc + $signed({{(ACC_W-PROD_W){p1[PROD_W-1]}}, p1});
        shifted = sum >>> FRAC;
        if (shifted > SAT_MAX) begin
            sat = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            sat = shifted[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1           <= '0;
            v1           <= 1'b0;
            last1        <= 1'b0;
            t_cnt        <= '0;
            e_cnt        <= '0;
            acc          <= '0;
            bus.o_dw     <= '0;
            bus.o_addr_w <= '0;
            bus.o_valid  <= 1'b0;
            bus.o_done   <= 1'b0;
        end else begin
            if (bus.i_valid) begin
                p1    <= PROD_W'(bus.i_d) * PROD_W'(bus.i_x);
                v1    <= 1'b1;
                last1 <= (t_cnt == T_LAST);
                t_cnt <= (t_cnt == T_LAST) ? '0 : t_cnt + T_W'(1);
            end else begin
                v1 <= 1'b0;
            end

            bus.o_valid <= 1'b0;
            bus.o_done  <= 1'b0;
            if (v1) begin
                if (last1) begin
                    acc          <= '0;
                    bus.o_dw     <= sat;
                    bus.o_addr_w <= e_cnt;
                    bus.o_valid  <= 1'b1;
                    bus.o_done   <= (e_cnt == E_LAST);
                    e_cnt        <= (e_cnt == E_LAST) ? '0 : e_cnt + ADDR_WIDTH'(1);
                end else begin
                    acc <= sum;
                end
            end
        end
    end
endmodule

// File: tb/tb_upd_dw_mac.sv
// Directed bench for upd_dw_mac: latency, sign/truncation, saturation, bubbles with a
// full address sweep, back-to-back elements and asynchronous reset mid-element.
module tb_upd_dw_mac;
    localparam int WIDTH      = 16;
    localparam int FRAC       = 12;
    localparam int TIMESTEP   = 7;
    localparam int NUM_CELL   = 2;
    localparam int NUM_INPUT  = 3;
    localparam int ADDR_WIDTH = 12;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   dw_q[$];
    int   addr_q[$];
    int   done_q[$];
    int   exp_q[$];

    upd_dw_mac_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    upd_dw_mac #(
        .WIDTH(WIDTH), .FRAC(FRAC), .TIMESTEP(TIMESTEP),
        .NUM_CELL(NUM_CELL), .NUM_INPUT(NUM_INPUT), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Every emitted element is captured mid-cycle for later comparison.
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            dw_q.push_back(int'(bus.o_dw));
            addr_q.push_back(int'(bus.o_addr_w));
            done_q.push_back(int'(bus.o_done));
        end
    end

    task checkOutput(input string tag, input logic signed [31:0] observed,
                     input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task applyStimulus(input logic valid, input int d, input int x);
        bus.i_valid = valid;
        bus.i_d     = WIDTH'(d);
        bus.i_x     = WIDTH'(x);
        @(posedge clk);
        #1;
    endtask

    task feedElement(input int d, input int x);
        repeat (TIMESTEP) applyStimulus(1'b1, d, x);
    endtask

    task clearQueues();
        dw_q.delete();
        addr_q.delete();
        done_q.delete();
    endtask

    task drainOutputs(input string tag, input int n);
        int budget;
        budget = 40;
        while (dw_q.size() < n && budget > 0) begin
            applyStimulus(1'b0, 0, 0);
            budget--;
        end
        checkOutput(tag, dw_q.size(), n);
    endtask

    task checkElement(input string tag, input int idx, input int dw, input int addr, input int done);
        if (idx < dw_q.size()) begin
            checkOutput({tag, "_dw"}, dw_q[idx], dw);
            checkOutput({tag, "_addr"}, addr_q[idx], addr);
            checkOutput({tag, "_done"}, done_q[idx], done);
        end
    endtask

    initial begin
        longint acc_m;
        longint sh;
        int     dv;
        int     xv;

        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_d     = '0;
        bus.i_x     = '0;
        #2;
        checkOutput("reset_dw", bus.o_dw, 0);
        checkOutput("reset_addr", bus.o_addr_w, 0);
        checkOutput("reset_valid", bus.o_valid, 0);
        checkOutput("reset_done", bus.o_done, 0);
        #10;
        rst = 1'b0;

        $display("[TB] basic accumulate and latency");
        clearQueues();
        feedElement(4096, 2048);
        bus.i_valid = 1'b0;
        checkOutput("t1_valid_early", bus.o_valid, 0);
        applyStimulus(1'b0, 0, 0);
        checkOutput("t1_valid", bus.o_valid, 1);
        checkOutput("t1_dw", bus.o_dw, 14336);
        checkOutput("t1_addr", bus.o_addr_w, 0);
        checkOutput("t1_done", bus.o_done, 0);
        applyStimulus(1'b0, 0, 0);
        checkOutput("t1_valid_pulse", bus.o_valid, 0);
        checkOutput("t1_dw_hold", bus.o_dw, 14336);

        $display("[TB] sign and truncation");
        clearQueues();
        feedElement(-4096, 4096);
        feedElement(1, 1);
        feedElement(-1, 1);
        drainOutputs("t2_count", 3);
        checkElement("t2_neg", 0, -28672, 1, 0);
        checkElement("t2_tiny_pos", 1, 0, 2, 0);
        checkElement("t2_tiny_neg", 2, -1, 3, 0);

        $display("[TB] saturation");
        clearQueues();
        feedElement(32767, 32767);
        feedElement(-32768, 32767);
        drainOutputs("t3_count", 2);
        checkElement("t3_sat_pos", 0, 32767, 4, 0);
        checkElement("t3_sat_neg", 1, -32768, 5, 1);

        $display("[TB] bubbles and full sweep");
        clearQueues();
        exp_q.delete();
        acc_m = 0;
        for (int k = 0; k < NUM_CELL * NUM_INPUT * TIMESTEP; k++) begin
            dv    = int'($signed(16'($urandom)));
            xv    = int'($signed(16'($urandom)));
            acc_m = acc_m + longint'(dv) * longint'(xv);
            if (k % TIMESTEP == TIMESTEP - 1) begin
                sh = acc_m >>> FRAC;
                if (sh > 32767) sh = 32767;
                if (sh < -32768) sh = -32768;
                exp_q.push_back(int'(sh));
                acc_m = 0;
            end
            applyStimulus(1'b1, dv, xv);
            applyStimulus(1'b0, 0, 0);
            applyStimulus(1'b0, 0, 0);
        end
        drainOutputs("t4_count", 6);
        for (int e = 0; e < 6; e++) begin
            checkElement($sformatf("t4_elem%0d", e), e, exp_q[e], e, (e == 5) ? 1 : 0);
        end

        $display("[TB] back-to-back elements");
        clearQueues();
        feedElement(4096, 4096);
        feedElement(4096, -4096);
        drainOutputs("t5_count", 2);
        checkElement("t5_first", 0, 28672, 0, 0);
        checkElement("t5_second", 1, -28672, 1, 0);

        $display("[TB] reset mid-element");
        clearQueues();
        repeat (4) applyStimulus(1'b1, 4096, 4096);
        bus.i_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_dw", bus.o_dw, 0);
        checkOutput("t6_rst_addr", bus.o_addr_w, 0);
        checkOutput("t6_rst_valid", bus.o_valid, 0);
        checkOutput("t6_rst_done", bus.o_done, 0);
        #2;
        rst = 1'b0;
        clearQueues();
        feedElement(4096, 4096);
        drainOutputs("t6_count", 1);
        checkElement("t6_after", 0, 28672, 0, 0);
        applyStimulus(1'b0, 0, 0);
        applyStimulus(1'b0, 0, 0);
        checkOutput("t6_no_extra", dw_q.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
